adrv9001_tdd_seq: RTL

Multi-channel TDD enable sequencer for the ADRV9001 SSI datapath. It is parametrised in channel count and counter width. Each channel turns a level `tdd_en` request into an ordered pair of outputs: `enable` drives the device RX/TX enable pin, and `ssi_en` gates the SSI datapath. Programmable lead and lag counts set the spacing, and a per-channel abort forces immediate teardown. The block sits between the register bank and the per-channel rx/tx SSI blocks and replaces their ad-hoc enable counters.

---
 rtl/adrv9001_tdd_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/adrv9001_tdd_seq.sv
// adrv9001_tdd_seq: multi-channel TDD enable sequencer for the ADRV9001 SSI path.
// Each channel turns a level tdd_en request into an ordered enable / ssi_en pair
// with programmable lead (ssi_enable_cnt) and lag (ssi_disable_cnt, disable_cnt)
// spacing, plus a per-channel abort that forces immediate teardown.
// Optional feature: define ADRV9001_TDD_SEQ_ERR_EN to add the sticky err output
// and its err_clr input (restart-during-teardown / abort-while-running flag).
module adrv9001_tdd_seq #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [NUM_CH-1:0]             tdd_en,
    input  logic [NUM_CH-1:0]             abort,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   ssi_enable_cnt,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   ssi_disable_cnt,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   disable_cnt,
`ifdef ADRV9001_TDD_SEQ_ERR_EN
    input  logic [NUM_CH-1:0]             err_clr,
`endif
    output logic [NUM_CH-1:0]             enable,
    output logic [NUM_CH-1:0]             ssi_en,
    output logic [NUM_CH-1:0]             busy
`ifdef ADRV9001_TDD_SEQ_ERR_EN
    ,
    output logic [NUM_CH-1:0]             err
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP     = 3'd1,
        ACTIVE   = 3'd2,
        SSI_HOLD = 3'd3,
        DIS_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t               state_reg, state_next;
            logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
            logic                 enable_reg, enable_next;
            logic                 ssi_reg, ssi_next;
            logic                 enter_dis;
            logic [CNT_WIDTH-1:0] ena_cnt, sdis_cnt, dis_cnt;

            assign ena_cnt  = ssi_enable_cnt[gi*CNT_WIDTH +: CNT_WIDTH];
            assign sdis_cnt = ssi_disable_cnt[gi*CNT_WIDTH +: CNT_WIDTH];
            assign dis_cnt  = disable_cnt[gi*CNT_WIDTH +: CNT_WIDTH];

            // Channel state, down-counter and registered outputs.
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    enable_reg <= 1'b0;
                    ssi_reg    <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    enable_reg <= enable_next;
                    ssi_reg    <= ssi_next;
                end
            end

            // Next-state logic; enter_dis funnels every path into the common
            // DIS_HOLD entry rule so the zero-count shortcut lives in one place.
            always_comb begin
                state_next  = state_reg;
                cnt_next    = cnt_reg;
                enable_next = enable_reg;
                ssi_next    = ssi_reg;
                enter_dis   = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (tdd_en[gi] && !abort[gi]) begin
                            enable_next = 1'b1;
                            if (ena_cnt == '0) begin
                                ssi_next   = 1'b1;
                                state_next = ACTIVE;
                            end else begin
                                cnt_next   = ena_cnt - CNT_ONE;
                                state_next = RAMP;
                            end
                        end
                    end
                    RAMP: begin
                        if (abort[gi]) begin
                            enter_dis = 1'b1;
                        end else if (cnt_reg == '0) begin
                            ssi_next   = 1'b1;
                            state_next = ACTIVE;
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                    ACTIVE: begin
                        if (abort[gi]) begin
                            enter_dis = 1'b1;
                        end else if (!tdd_en[gi]) begin
                            if (sdis_cnt == '0) begin
                                enter_dis = 1'b1;
                            end else begin
                                cnt_next   = sdis_cnt - CNT_ONE;
                                state_next = SSI_HOLD;
                            end
                        end
                    end
                    SSI_HOLD: begin
                        if (abort[gi] || cnt_reg == '0) begin
                            enter_dis = 1'b1;
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                    DIS_HOLD: begin
                        if (cnt_reg == '0) begin
                            enable_next = 1'b0;
                            state_next  = IDLE;
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                    default: begin
                        enable_next = 1'b0;
                        ssi_next    = 1'b0;
                        state_next  = IDLE;
                    end
                endcase
                if (enter_dis) begin
                    ssi_next = 1'b0;
                    if (dis_cnt == '0) begin
                        enable_next = 1'b0;
                        state_next  = IDLE;
                    end else begin
                        cnt_next   = dis_cnt - CNT_ONE;
                        state_next = DIS_HOLD;
                    end
                end
            end

            assign enable[gi] = enable_reg;
            assign ssi_en[gi] = ssi_reg;
            assign busy[gi]   = (state_reg != IDLE);

`ifdef ADRV9001_TDD_SEQ_ERR_EN
            logic err_reg;
            logic err_set;

            assign err_set = (tdd_en[gi] && (state_reg == SSI_HOLD || state_reg == DIS_HOLD)) ||
                             (abort[gi]  && (state_reg == RAMP || state_reg == ACTIVE ||
                                             state_reg == SSI_HOLD));

            // Sticky error flag; a new set event wins over a simultaneous clear.
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    err_reg <= 1'b0;
                end else if (err_set) begin
                    err_reg <= 1'b1;
                end else if (err_clr[gi]) begin
                    err_reg <= 1'b0;
                end
            end

            assign err[gi] = err_reg;
`endif
        end
    endgenerate

endmodule
